// File: rtl/nsum_pkg.sv
// nsum_pkg: shared widths, FSM state type and the golden N-sum function for
// the N-sum requester slice.
package nsum_pkg;
  localparam int N_W   = 3;
  localparam int SUM_W = 4;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_SUM, ACK, DRAIN, RESULT
  } nsum_req_state_t;

  // Triangular number N*(N+1)/2, truncated to SUM_W bits.
  function automatic logic [SUM_W-1:0] nsum_golden(input logic [N_W-1:0] n);
    logic [2*N_W:0] nn;
    logic [2*N_W:0] p;
    nn = (2*N_W+1)'(n);
    p  = (nn * (nn + 1'b1)) >> 1;
    return p[SUM_W-1:0];
  endfunction
endpackage

// File: rtl/nsum_req_fifo.sv
// nsum_req_fifo: synchronous FIFO holding pending N requests.
// Ports: clk, reset (sync, active-high), push/push_data, pop, head (first
// entry, valid when !empty), full, empty. Push while full is ignored, pop
// while empty is ignored.
module nsum_req_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  // Extra MSB on the pointers distinguishes full from empty.
  logic [AW:0] wp, rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) begin
        mem[wp[AW-1:0]] <= push_data;
        wp <= wp + 1'b1;
      end
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/nsum_requester.sv
// nsum_requester: buffers N requests, issues them one at a time to the N-sum
// engine (nsum_n/nsum_n_valid -> nsum_sum/nsum_sum_valid -> nsum_ack) and
// returns {n, sum} on a valid/ready result port.
// Ports: clk, reset (sync, active-high); req_valid/req_n/req_ready upstream;
// res_valid/res_ready/res_n/res_sum/res_timeout/res_mismatch/err_count
// downstream; nsum_* engine handshake; busy.
// Optional feature: define NSUM_CHECK_EN to compare each sum against the
// golden value (res_mismatch, saturating err_count). Without it both are 0.
module nsum_requester
  import nsum_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [N_W-1:0]   req_n,
  output logic             req_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N_W-1:0]   res_n,
  output logic [SUM_W-1:0] res_sum,
  output logic             res_timeout,
  output logic             res_mismatch,
  output logic [7:0]       err_count,
  output logic [N_W-1:0]   nsum_n,
  output logic             nsum_n_valid,
  input  logic [SUM_W-1:0] nsum_sum,
  input  logic             nsum_sum_valid,
  output logic             nsum_ack,
  output logic             busy
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  nsum_req_state_t  state;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [SUM_W-1:0] sum_cap;
  logic [N_W-1:0]   head;
  logic             full, empty, pop;
  logic             tmo_hit, done_hit, chk_mm;

  assign req_ready = !full;
  assign pop       = (state == IDLE) && !empty;
  assign busy      = (state != IDLE) || !empty;

  nsum_req_fifo #(.W(N_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_valid && !full),
    .push_data (req_n),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // A sum arriving in the same cycle as the deadline takes priority.
  assign cnt_nx   = cnt + 1'b1;
  assign tmo_hit  = (state == WAIT_SUM) && !nsum_sum_valid && (cnt_nx == CNT_W'(TIMEOUT));
  // The engine holds sum_valid one cycle past Ack; DRAIN waits that out.
  assign done_hit = (state == DRAIN) && !nsum_sum_valid;

`ifdef NSUM_CHECK_EN
  assign chk_mm = (sum_cap != nsum_golden(nsum_n));

  always_ff @(posedge clk) begin
    if (reset) err_count <= '0;
    else if ((tmo_hit || (done_hit && chk_mm)) && err_count != 8'hFF)
      err_count <= err_count + 1'b1;
  end
`else
  assign chk_mm    = 1'b0;
  assign err_count = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      sum_cap      <= '0;
      nsum_n       <= '0;
      nsum_n_valid <= 1'b0;
      nsum_ack     <= 1'b0;
      res_valid    <= 1'b0;
      res_n        <= '0;
      res_sum      <= '0;
      res_timeout  <= 1'b0;
      res_mismatch <= 1'b0;
    end else begin
      nsum_n_valid <= 1'b0;
      nsum_ack     <= 1'b0;
      case (state)
        IDLE: if (!empty) begin
          if (head == '0) begin
            // The engine never terminates on N=0, so answer locally.
            res_n     <= '0;
            res_sum   <= '0;
            res_valid <= 1'b1;
            state     <= RESULT;
          end else begin
            nsum_n       <= head;
            nsum_n_valid <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_SUM;
        end
        WAIT_SUM: begin
          if (nsum_sum_valid) begin
            sum_cap  <= nsum_sum;
            nsum_ack <= 1'b1;
            state    <= ACK;
          end else begin
            cnt <= cnt_nx;
            if (tmo_hit) begin
              res_n       <= nsum_n;
              res_sum     <= '0;
              res_timeout <= 1'b1;
              res_valid   <= 1'b1;
              state       <= RESULT;
            end
          end
        end
        ACK: state <= DRAIN;
        DRAIN: if (done_hit) begin
          res_n        <= nsum_n;
          res_sum      <= sum_cap;
          res_mismatch <= chk_mm;
          res_valid    <= 1'b1;
          state        <= RESULT;
        end
        RESULT: if (res_ready) begin
          res_valid    <= 1'b0;
          res_n        <= '0;
          res_sum      <= '0;
          res_timeout  <= 1'b0;
          res_mismatch <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nsum_requester.sv
// tb_nsum_requester: directed bench for nsum_requester with a behavioural
// N-sum engine (mode 0 correct, mode 1 never answers, mode 2 always returns 5).
module tb_nsum_requester;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_n = '0;
  logic       req_ready;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [2:0] res_n;
  logic [3:0] res_sum;
  logic       res_timeout, res_mismatch;
  logic [7:0] err_count;
  logic [2:0] nsum_n;
  logic       nsum_n_valid;
  logic [3:0] nsum_sum;
  logic       nsum_sum_valid;
  logic       nsum_ack;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nsum_requester dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_n(res_n), .res_sum(res_sum),
    .res_timeout(res_timeout), .res_mismatch(res_mismatch), .err_count(err_count),
    .nsum_n(nsum_n), .nsum_n_valid(nsum_n_valid), .nsum_sum(nsum_sum),
    .nsum_sum_valid(nsum_sum_valid), .nsum_ack(nsum_ack), .busy(busy)
  );

  // Engine model: sum_valid rises N+2 cycles after the issue pulse, holds
  // until Ack and stays high one extra cycle after it.
  int   mode = 0;
  int   lat  = 0;
  logic ack_d = 1'b0;
  int   nv_cnt = 0;
  int   ack_cnt = 0;

  always @(posedge clk) begin
    if (reset) begin
      nsum_sum_valid <= 1'b0;
      nsum_sum       <= '0;
      lat            <= 0;
      ack_d          <= 1'b0;
    end else begin
      ack_d <= nsum_ack;
      if (ack_d) nsum_sum_valid <= 1'b0;
      if (nsum_n_valid && mode != 1) lat <= int'(nsum_n) + 1;
      else if (lat > 0) begin
        lat <= lat - 1;
        if (lat == 1) begin
          nsum_sum_valid <= 1'b1;
          nsum_sum <= (mode == 2) ? 4'd5 : 4'(((int'(nsum_n) * (int'(nsum_n) + 1)) / 2) % 16);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (nsum_n_valid) nv_cnt++;
    if (nsum_ack) ack_cnt++;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push(input logic [2:0] n);
    req_valid = 1'b1; req_n = n;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for res_valid, samples the result, then accepts it.
  task automatic get_result(input int budget, output bit ok, output logic [2:0] n,
                            output logic [3:0] s, output logic to, output logic mm,
                            output logic [7:0] ec, output int cyc);
    ok = 1'b0; cyc = 0; n = '0; s = '0; to = 1'b0; mm = 1'b0; ec = '0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (res_valid) begin ok = 1'b1; break; end
    end
    if (ok) begin
      n = res_n; s = res_sum; to = res_timeout; mm = res_mismatch; ec = err_count;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({res_valid, res_timeout, res_mismatch, nsum_n_valid, nsum_ack, busy} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=000000",
        {res_valid, res_timeout, res_mismatch, nsum_n_valid, nsum_ack, busy}); end
    total++; if ({res_n, res_sum, nsum_n, err_count} !== 18'h0) begin
      bad++; $display("FAIL reset_data got=%h want=0", {res_n, res_sum, nsum_n, err_count}); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_n3();
    bit ok; logic [2:0] n; logic [3:0] s; logic to, mm; logic [7:0] ec; int cyc;
    int nv0 = nv_cnt, ak0 = ack_cnt;
    mode = 0;
    push(3'd3);
    get_result(40, ok, n, s, to, mm, ec, cyc);
    total++; if (!ok) begin bad++; $display("FAIL n3_result_seen got=none want=res_valid"); end
    total++; if ({n, s, to, mm} !== {3'd3, 4'd6, 1'b0, 1'b0}) begin
      bad++; $display("FAIL n3_fields got n=%0d sum=%0d to=%b mm=%b want n=3 sum=6 to=0 mm=0", n, s, to, mm); end
    total++; if (nv_cnt - nv0 != 1) begin bad++; $display("FAIL n3_issue_pulses got=%0d want=1", nv_cnt - nv0); end
    total++; if (ack_cnt - ak0 != 1) begin bad++; $display("FAIL n3_ack_pulses got=%0d want=1", ack_cnt - ak0); end
  endtask

  task automatic test_n7();
    bit ok; logic [2:0] n; logic [3:0] s; logic to, mm; logic [7:0] ec; int cyc;
    int ak0 = ack_cnt;
    mode = 0;
    push(3'd7);
    get_result(40, ok, n, s, to, mm, ec, cyc);
    repeat (5) @(negedge clk);
    total++; if (!ok || n !== 3'd7 || s !== 4'd12) begin
      bad++; $display("FAIL n7_sum got ok=%0d n=%0d sum=%0d want n=7 sum=12", ok, n, s); end
    total++; if (ack_cnt - ak0 != 1) begin bad++; $display("FAIL n7_ack_pulses got=%0d want=1", ack_cnt - ak0); end
    total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL n7_idle_after got valid=%b busy=%b want 0 0", res_valid, busy); end
  endtask

  task automatic test_n0();
    bit ok; logic [2:0] n; logic [3:0] s; logic to, mm; logic [7:0] ec; int cyc;
    int nv0 = nv_cnt;
    push(3'd0);
    get_result(10, ok, n, s, to, mm, ec, cyc);
    total++; if (!ok || cyc > 2) begin bad++; $display("FAIL n0_latency got ok=%0d cycles=%0d want <=2", ok, cyc); end
    total++; if ({n, s, to} !== 8'h0) begin bad++; $display("FAIL n0_fields got n=%0d sum=%0d to=%b want 0 0 0", n, s, to); end
    total++; if (nv_cnt != nv0) begin bad++; $display("FAIL n0_no_issue got=%0d want=0", nv_cnt - nv0); end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [2:0] n; logic [3:0] s; logic to, mm; logic [7:0] ec; int cyc;
    logic [3:0] exp_sum [5] = '{4'd1, 4'd3, 4'd6, 4'd10, 4'd15};
    mode = 0; res_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      req_valid = 1'b1; req_n = 3'(k);
      @(negedge clk);
    end
    // Sixth request must be refused: 4 buffered + 1 in flight.
    req_n = 3'd6;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got req_ready=%b want=0", req_ready); end
    repeat (12) @(negedge clk);
    req_valid = 1'b0;
    total++; if (req_ready !== 1'b0 || res_valid !== 1'b1 || res_n !== 3'd1) begin
      bad++; $display("FAIL b2b_held got ready=%b valid=%b n=%0d want 0 1 1", req_ready, res_valid, res_n); end
    for (int k = 0; k < 5; k++) begin
      get_result(40, ok, n, s, to, mm, ec, cyc);
      total++; if (!ok || n !== 3'(k + 1) || s !== exp_sum[k]) begin
        bad++; $display("FAIL b2b_order%0d got ok=%0d n=%0d sum=%0d want n=%0d sum=%0d",
          k, ok, n, s, k + 1, exp_sum[k]); end
    end
    repeat (10) @(negedge clk);
    total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_drained got valid=%b busy=%b want 0 0", res_valid, busy); end
  endtask

  task automatic test_timeout();
    bit ok; logic [2:0] n; logic [3:0] s; logic to, mm; logic [7:0] ec; int cyc; int w;
    int ak0;
    do_reset();
    mode = 1; ak0 = ack_cnt;
    push(3'd2);
    w = 0;
    while (!nsum_n_valid && w < 10) begin @(negedge clk); w++; end
    total++; if (!nsum_n_valid) begin bad++; $display("FAIL tmo_issue got=0 want=1"); end
    get_result(40, ok, n, s, to, mm, ec, cyc);
    total++; if (!ok || cyc != 17) begin bad++; $display("FAIL tmo_latency got ok=%0d cycles=%0d want 17", ok, cyc); end
    total++; if ({n, s, to} !== {3'd2, 4'd0, 1'b1}) begin
      bad++; $display("FAIL tmo_fields got n=%0d sum=%0d to=%b want 2 0 1", n, s, to); end
`ifdef NSUM_CHECK_EN
    total++; if (ec !== 8'd1) begin bad++; $display("FAIL tmo_err_count got=%0d want=1", ec); end
`else
    total++; if (ec !== 8'd0) begin bad++; $display("FAIL tmo_err_count got=%0d want=0", ec); end
`endif
    total++; if (ack_cnt != ak0) begin bad++; $display("FAIL tmo_no_ack got=%0d want=0", ack_cnt - ak0); end
  endtask

  task automatic test_mismatch_and_reset();
    bit ok; logic [2:0] n; logic [3:0] s; logic to, mm; logic [7:0] ec; int cyc; int w;
    do_reset();
    mode = 2;
    push(3'd3);
    get_result(40, ok, n, s, to, mm, ec, cyc);
    total++; if (!ok || s !== 4'd5 || to !== 1'b0) begin
      bad++; $display("FAIL mm_sum got ok=%0d sum=%0d to=%b want 5 0", ok, s, to); end
`ifdef NSUM_CHECK_EN
    total++; if ({mm, ec} !== {1'b1, 8'd1}) begin bad++; $display("FAIL mm_flag got mm=%b ec=%0d want 1 1", mm, ec); end
`else
    total++; if ({mm, ec} !== 9'd0) begin bad++; $display("FAIL mm_flag got mm=%b ec=%0d want 0 0", mm, ec); end
`endif
    // Reset while stuck in WAIT_SUM with another request buffered.
    mode = 1;
    push(3'd3);
    push(3'd4);
    w = 0;
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy got=%b want=1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if ({res_valid, res_timeout, res_mismatch, nsum_n_valid, nsum_ack, busy, nsum_n, err_count} !== 17'h0) begin
      bad++; $display("FAIL rst_mid_state got=%h want=0",
        {res_valid, res_timeout, res_mismatch, nsum_n_valid, nsum_ack, busy, nsum_n, err_count}); end
    mode = 0;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++; $display("FAIL rst_fifo_dropped got busy=%b valid=%b want 0 0", busy, res_valid); end
    push(3'd5);
    get_result(40, ok, n, s, to, mm, ec, cyc);
    total++; if (!ok || n !== 3'd5 || s !== 4'd15) begin
      bad++; $display("FAIL rst_recover got ok=%0d n=%0d sum=%0d want 5 15", ok, n, s); end
  endtask

  initial begin
    test_reset();
    test_n3();
    test_n7();
    test_n0();
    test_back_to_back();
    test_timeout();
    test_mismatch_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
